// File: rtl/cordic_pkg.sv
// Shared constants, tag type and negate helper for the CORDIC request arbiter.
package cordic_pkg;

   localparam int               ANGLE_W = 16;
   localparam logic [ANGLE_W-1:0] ANG_90  = 16'h4000;
   localparam logic [ANGLE_W-1:0] ANG_180 = 16'h8000;
   localparam logic [ANGLE_W-1:0] X_INIT  = 16'h4D80;
   localparam int               LATENCY = 16;
   localparam int               ID_W    = 4;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            neg;
   } tag_t;

   // Two's-complement negate; the most negative code saturates to max positive.
   function automatic logic [ANGLE_W-1:0] neg_sat(input logic [ANGLE_W-1:0] v);
      return (v == ANG_180) ? 16'h7FFF : (~v + 1'b1);
   endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin grant: search starts at ptr, first active request wins (one-hot grant).
module cordic_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cordic_arb.sv
// Multi-requester front end for a fixed-latency CORDIC sin/cos datapath.
// Optional quadrant folding is enabled with CORDIC_ARB_QUAD_FOLD_EN.
module cordic_arb #(
   parameter int          NUM_REQ = 4,
   parameter int          LATENCY = cordic_pkg::LATENCY,
   parameter logic [15:0] X_INIT  = cordic_pkg::X_INIT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*16-1:0] req_angle,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [15:0]           x_start,
   output logic [15:0]           y_start,
   output logic [15:0]           angle,
   input  logic [15:0]           sine,
   input  logic [15:0]           cosine,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [15:0]           rsp_sine,
   output logic [15:0]           rsp_cosine,
   output logic [4:0]            inflight
);
   import cordic_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] grant;
   logic               gnt_any;
   logic               accept;
   logic [15:0]        sel_angle;
   logic [15:0]        fold_angle;
   logic               fold_neg;
   tag_t               tag_d;
   tag_t               tag_q [0:LATENCY];
   tag_t               tag_out;
   logic [NUM_REQ-1:0] rsp_hit;

   cordic_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (gnt_idx),
      .grant_any (gnt_any)
   );

   assign req_ready = reset ? '0 : grant;
   assign accept    = gnt_any & ~reset;

   always_comb begin
      sel_angle = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
      end
   end

`ifdef CORDIC_ARB_QUAD_FOLD_EN
   // Angles beyond +/-90 deg are rotated by 180 deg and the result negated.
   assign fold_neg   = sel_angle[15] ^ sel_angle[14];
   assign fold_angle = fold_neg ? (sel_angle ^ ANG_180) : sel_angle;
`else
   assign fold_neg   = 1'b0;
   assign fold_angle = sel_angle;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr     <= '0;
         x_start <= '0;
         y_start <= '0;
         angle   <= '0;
      end else if (accept) begin
         ptr     <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         x_start <= X_INIT;
         y_start <= '0;
         angle   <= fold_angle;
      end else begin
         x_start <= '0;
         y_start <= '0;
         angle   <= '0;
      end
   end

   always_comb begin
      tag_d       = '0;
      tag_d.valid = accept;
      tag_d.id    = ID_W'(gnt_idx);
      tag_d.neg   = fold_neg;
   end

   // Stage 0 aligns with x_start/angle; the last stage lines up with sine/cosine.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign tag_out = tag_q[LATENCY];

   always_comb begin
      rsp_hit = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_hit[i] = tag_out.valid && (tag_out.id == ID_W'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid  <= '0;
         rsp_sine   <= '0;
         rsp_cosine <= '0;
      end else begin
         rsp_valid <= rsp_hit;
         if (tag_out.valid) begin
            rsp_sine   <= tag_out.neg ? neg_sat(sine)   : sine;
            rsp_cosine <= tag_out.neg ? neg_sat(cosine) : cosine;
         end
      end
   end

   // Retirement counts on the edge that raises rsp_valid, so the ceiling is LATENCY+1.
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight <= '0;
      end else if (accept && !tag_out.valid) begin
         inflight <= inflight + 1'b1;
      end else if (!accept && tag_out.valid) begin
         inflight <= inflight - 1'b1;
      end
   end

endmodule

// File: tb/tb_cordic_arb.sv
// Bench for cordic_arb: behavioural sin/cos datapath, scoreboard of expected responses.
module tb_cordic_arb;

   localparam int N   = 4;
   localparam int LAT = 16;

`ifdef CORDIC_ARB_QUAD_FOLD_EN
   localparam bit FOLD = 1'b1;
`else
   localparam bit FOLD = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid;
   logic [N*16-1:0] req_angle;
   logic [N-1:0]    req_ready;
   logic [15:0]     x_start, y_start, angle;
   logic [15:0]     sine, cosine;
   logic [N-1:0]    rsp_valid;
   logic [15:0]     rsp_sine, rsp_cosine;
   logic [4:0]      inflight;

   always #5 clock = ~clock;

   cordic_arb #(.NUM_REQ(N), .LATENCY(LAT), .X_INIT(16'h4D80)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_angle  (req_angle),
      .req_ready  (req_ready),
      .x_start    (x_start),
      .y_start    (y_start),
      .angle      (angle),
      .sine       (sine),
      .cosine     (cosine),
      .rsp_valid  (rsp_valid),
      .rsp_sine   (rsp_sine),
      .rsp_cosine (rsp_cosine),
      .inflight   (inflight)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      int d;
      total++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
      end
   endtask

   function automatic logic [15:0] q15(input real v);
      int r;
      r = $rtoi(v * 32767.0 + ((v >= 0.0) ? 0.5 : -0.5));
      return r[15:0];
   endfunction

   function automatic real ang_rad(input logic [15:0] a);
      return real'($signed(a)) * 3.14159265358979 / 32768.0;
   endfunction

   // Behavioural datapath: keeps flowing through reset, LAT clocks after sampling.
   logic [15:0] dp_s [LAT];
   logic [15:0] dp_c [LAT];
   logic        force_sine = 1'b0;

   initial for (int i = 0; i < LAT; i++) begin dp_s[i] = '0; dp_c[i] = '0; end

   always @(posedge clock) begin
      for (int i = LAT - 1; i > 0; i--) begin
         dp_s[i] <= dp_s[i-1];
         dp_c[i] <= dp_c[i-1];
      end
      if (x_start != 16'h0) begin
         dp_s[0] <= force_sine ? 16'h8000 : q15($sin(ang_rad(angle)));
         dp_c[0] <= q15($cos(ang_rad(angle)));
      end else begin
         dp_s[0] <= '0;
         dp_c[0] <= '0;
      end
   end

   assign sine   = dp_s[LAT-1];
   assign cosine = dp_c[LAT-1];

   typedef struct {
      int          id;
      logic [15:0] s;
      logic [15:0] c;
      int          tol;
      int          edge_no;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         mon_e;
   int           edge_cnt = 0;
   int           ptr_m    = 0;
   logic [15:0]  last_s   = '0;
   logic [15:0]  last_c   = '0;
   logic [N-1:0] acc_last = '0;
   logic [N-1:0] exp_rdy;

   always @(posedge clock) begin
      edge_cnt <= edge_cnt + 1;
      if (reset) begin
         sb_q.delete();
         ptr_m  <= 0;
         last_s <= '0;
         last_c <= '0;
      end
   end

   always @(negedge clock) begin
      if (rsp_valid != '0) begin
         if (sb_q.size() == 0) begin
            check("rsp_spurious", int'(rsp_valid), 0);
         end else begin
            mon_e = sb_q.pop_front();
            check("rsp_id", int'(rsp_valid), 1 << mon_e.id);
            check("rsp_lat", edge_cnt - mon_e.edge_no, LAT + 1);
            check("rsp_sin", int'($signed(rsp_sine)), int'($signed(mon_e.s)), mon_e.tol);
            check("rsp_cos", int'($signed(rsp_cosine)), int'($signed(mon_e.c)), 16);
         end
         last_s = rsp_sine;
         last_c = rsp_cosine;
      end else begin
         check("hold_sin", int'(rsp_sine), int'(last_s));
         check("hold_cos", int'(rsp_cosine), int'(last_c));
      end
      check("inflight", int'(inflight), sb_q.size());

      exp_rdy = '0;
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr_m + k) % N;
            if (exp_rdy == '0 && req_valid[idx]) exp_rdy[idx] = 1'b1;
         end
      end
      check("ready", int'(req_ready), int'(exp_rdy));

      acc_last = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
         if (acc_last[i]) begin
            logic [15:0] a;
            exp_t        e;
            a = req_angle[i*16 +: 16];
            e.id      = i;
            e.s       = q15($sin(ang_rad(a)));
            e.c       = q15($cos(ang_rad(a)));
            e.tol     = 16;
            e.edge_no = edge_cnt + 1;
            if (force_sine) begin
               e.s   = FOLD ? 16'h7FFF : 16'h8000;
               e.tol = 0;
            end
            sb_q.push_back(e);
            ptr_m = (i + 1) % N;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || inflight != 0) && n < max_cyc) begin
         @(negedge clock);
         n++;
      end
      check("drain_timeout", sb_q.size(), 0);
      tick();
   endtask

   initial begin
      int seen;
      req_valid = '0;
      req_angle = '0;

      // reset state, with requests pending to show ready is held low
      req_valid = 4'hF;
      repeat (3) tick();
      @(negedge clock);
      check("rst_ready", int'(req_ready), 0);
      check("rst_x", int'(x_start), 0);
      check("rst_angle", int'(angle), 0);
      check("rst_rspv", int'(rsp_valid), 0);
      check("rst_inflight", int'(inflight), 0);
      tick();
      req_valid = '0;
      reset = 1'b0;
      tick();

      // single 45 deg request
      req_angle[15:0] = 16'h2000;
      req_valid = 4'b0001;
      @(negedge clock);
      check("t1_ready", int'(req_ready), 1);
      tick();
      req_valid = '0;
      check("t1_x", int'(x_start), 16'h4D80);
      check("t1_y", int'(y_start), 0);
      check("t1_angle", int'(angle), 16'h2000);
      tick();
      check("t1_idle_x", int'(x_start), 0);
      check("t1_idle_angle", int'(angle), 0);
      drain(40);
      check("t1_sin", int'(rsp_sine), 16'h5A80, 16);
      check("t1_cos", int'(rsp_cosine), 16'h5A80, 16);

      // all four requesters continuously valid
      do_reset();
      for (int i = 0; i < N; i++) req_angle[i*16 +: 16] = 16'h0C00 + 16'(i * 16'h1700);
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         check("rr_grant", int'(req_ready), 1 << (k % N));
      end
      repeat (14) @(negedge clock);
      check("rr_sat", int'(inflight), LAT + 1);
      repeat (6) @(negedge clock);
      check("rr_sat_hold", int'(inflight), LAT + 1);
      tick();
      req_valid = '0;
      drain(40);

      // 135 deg: folded to -45 deg and negated when the fold is built in
      do_reset();
      req_angle[15:0] = 16'h6000;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      check("fold_angle", int'(angle), FOLD ? 16'hE000 : 16'h6000);
      drain(40);
      check("fold_sin", int'($signed(rsp_sine)), 23168, 16);
      check("fold_cos", int'($signed(rsp_cosine)), -23168, 16);

      // reset with three results still in flight
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req_angle[k*16 +: 16] = 16'(16'h1000 * (k + 1));
         req_valid = 4'(1 << k);
         tick();
      end
      req_valid = '0;
      repeat (5) tick();
      check("mid_inflight_pre", int'(inflight), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_inflight", int'(inflight), 0);
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (rsp_valid != '0) seen++;
      end
      check("mid_no_rsp", seen, 0);
      tick();
      req_valid = 4'b1010;
      @(negedge clock);
      check("mid_ptr", int'(req_ready), 4'b0010);
      tick();
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      drain(40);

      // issue and retire on the same edge at inflight 9
      req_angle[15:0] = 16'h1800;
      req_valid = 4'b0001;
      repeat (9) @(posedge clock);
      #1;
      req_valid = '0;
      repeat (8) @(posedge clock);
      #1;
      req_valid = 4'b0001;
      @(negedge clock);
      check("same_pre", int'(inflight), 9);
      tick();
      req_valid = '0;
      check("same_post", int'(inflight), 9);
      check("same_rsp", int'(rsp_valid), 1);
      drain(40);

      // datapath returns the most negative sine
      force_sine = 1'b1;
      req_angle[15:0] = 16'h6000;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      force_sine = 1'b0;
      drain(40);
      check("sat_sin", int'(rsp_sine), FOLD ? 16'h7FFF : 16'h8000);

      // random traffic; requesters hold until accepted
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || acc_last[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_angle[i*16 +: 16] = 16'($urandom());
            end
         end
         tick();
      end
      req_valid = '0;
      drain(60);
      check("final_inflight", int'(inflight), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
